// File: rtl/axi_rd_pkg.sv
// rtl/axi_rd_pkg.sv - shared types and constants for the AXI burst read master
package axi_rd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } rd_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int         AXI_4K         = 4096;

  // log2 of a power-of-two byte count, as encoded in AxSIZE
  function automatic logic [2:0] axi_size(input int bytes);
    axi_size = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == bytes) axi_size = 3'(i);
    end
  endfunction

endpackage

// File: rtl/axi_burst_len_calc.sv
// rtl/axi_burst_len_calc.sv - beats for the next INCR burst, capped by remaining length, MAX_BURST and 4 KB page
module axi_burst_len_calc
  import axi_rd_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 32
) (
  input  logic [LEN_W-1:0] rem_i,
  input  logic [11:0]      addr_i,
  output logic [8:0]       blen_o
);

  localparam logic [2:0] SIZE = axi_size(DATA_W / 8);
  localparam int         CW   = (LEN_W > 13) ? LEN_W : 13;

  logic [12:0]   to_4k_bytes;
  logic [12:0]   to_4k_beats;
  logic [12:0]   cap;
  logic [CW-1:0] rem_w;
  logic [CW-1:0] cap_w;

  always_comb begin
    to_4k_bytes = 13'(AXI_4K) - {1'b0, addr_i};
    to_4k_beats = to_4k_bytes >> SIZE;
    cap         = (to_4k_beats < 13'(MAX_BURST)) ? to_4k_beats : 13'(MAX_BURST);
    rem_w       = CW'(rem_i);
    cap_w       = CW'(cap);
    blen_o      = (rem_w < cap_w) ? rem_w[8:0] : cap_w[8:0];
  end

endmodule

// File: rtl/axi_burst_read_master.sv
// rtl/axi_burst_read_master.sv - AXI4 read master fetching a contiguous block as 4 KB-safe INCR bursts
module axi_burst_read_master
  import axi_rd_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ID_W      = 6,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic [31:0]       addr_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   m00_axi_arid,
  output logic [31:0]       m00_axi_araddr,
  output logic [7:0]        m00_axi_arlen,
  output logic [2:0]        m00_axi_arsize,
  output logic [1:0]        m00_axi_arburst,
  output logic              m00_axi_arlock,
  output logic [3:0]        m00_axi_arcache,
  output logic [2:0]        m00_axi_arprot,
  output logic [3:0]        m00_axi_arqos,
  output logic              m00_axi_arvalid,
  input  logic              m00_axi_arready,
  input  logic [ID_W-1:0]   m00_axi_rid,
  input  logic [DATA_W-1:0] m00_axi_rdata,
  input  logic [1:0]        m00_axi_rresp,
  input  logic              m00_axi_rlast,
  input  logic              m00_axi_rvalid,
  output logic              m00_axi_rready
);

  localparam int         BYTES = DATA_W / 8;
  localparam logic [2:0] SIZE  = axi_size(BYTES);

  rd_state_t        state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [8:0]       blen_q, blen_d;
  logic [7:0]       arlen_q;
  logic [7:0]       bcnt_q, bcnt_d;
  logic             err_q, err_d;
  logic             r_hs;
  logic             enter_addr;
  logic             rid_unused;

  // rid is not checked: only one burst is ever outstanding
  assign rid_unused = ^m00_axi_rid;

  assign r_hs = (state_q == DATA) && m00_axi_rvalid && out_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    bcnt_d  = bcnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          addr_d  = addr_in & ~32'(BYTES - 1);
          rem_d   = len_in;
          err_d   = 1'b0;
          state_d = (len_in == '0) ? DONE : ADDR;
        end
      end
      ADDR: begin
        if (m00_axi_arready) begin
          bcnt_d  = arlen_q;
          state_d = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          err_d  = err_q | (m00_axi_rresp != 2'b00) | (m00_axi_rlast != (bcnt_q == 8'd0));
          bcnt_d = bcnt_q - 8'd1;
          if (bcnt_q == 8'd0) begin
            rem_d   = rem_q - LEN_W'(blen_q);
            addr_d  = addr_q + (32'(blen_q) << SIZE);
            state_d = (rem_d == '0) ? DONE : ADDR;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sized from the next-state pointers so the burst is ready the cycle ADDR is entered
  axi_burst_len_calc #(
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST),
    .LEN_W    (LEN_W)
  ) u_len_calc (
    .rem_i (rem_d),
    .addr_i(addr_d[11:0]),
    .blen_o(blen_d)
  );

  assign enter_addr = (state_d == ADDR) && (state_q != ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      blen_q  <= '0;
      arlen_q <= '0;
      bcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
      if (enter_addr) begin
        blen_q  <= blen_d;
        arlen_q <= 8'(blen_d - 9'd1);
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = (state_q == DONE) && err_q;
  assign out_valid = (state_q == DATA) && m00_axi_rvalid;
  assign out_data  = (state_q == DATA) ? m00_axi_rdata : '0;

  assign m00_axi_rready  = (state_q == DATA) && out_ready;
  assign m00_axi_arvalid = (state_q == ADDR);
  assign m00_axi_araddr  = addr_q;
  assign m00_axi_arlen   = arlen_q;
  assign m00_axi_arid    = '0;
  assign m00_axi_arsize  = SIZE;
  assign m00_axi_arburst = AXI_BURST_INCR;
  assign m00_axi_arlock  = 1'b0;
  assign m00_axi_arcache = 4'b0011;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_arqos   = 4'b0000;

endmodule

// File: tb/tb_axi_burst_read_master.sv
// tb/tb_axi_burst_read_master.sv - self-checking bench for axi_burst_read_master
module tb_axi_burst_read_master;

  localparam int DW = 32;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_in;
  logic [31:0]   addr_in;
  logic [31:0]   len_in;
  logic          busy, done, err;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] m00_axi_arid;
  logic [31:0]   m00_axi_araddr;
  logic [7:0]    m00_axi_arlen;
  logic [2:0]    m00_axi_arsize;
  logic [1:0]    m00_axi_arburst;
  logic          m00_axi_arlock;
  logic [3:0]    m00_axi_arcache;
  logic [2:0]    m00_axi_arprot;
  logic [3:0]    m00_axi_arqos;
  logic          m00_axi_arvalid;
  logic          m00_axi_arready;
  logic [IW-1:0] m00_axi_rid;
  logic [DW-1:0] m00_axi_rdata;
  logic [1:0]    m00_axi_rresp;
  logic          m00_axi_rlast;
  logic          m00_axi_rvalid;
  logic          m00_axi_rready;

  always #5 clk = ~clk;

  axi_burst_read_master #(.DATA_W(DW), .ID_W(IW), .MAX_BURST(16), .LEN_W(32)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .addr_in(addr_in), .len_in(len_in),
    .busy(busy), .done(done), .err(err),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .m00_axi_arid(m00_axi_arid), .m00_axi_araddr(m00_axi_araddr), .m00_axi_arlen(m00_axi_arlen),
    .m00_axi_arsize(m00_axi_arsize), .m00_axi_arburst(m00_axi_arburst), .m00_axi_arlock(m00_axi_arlock),
    .m00_axi_arcache(m00_axi_arcache), .m00_axi_arprot(m00_axi_arprot), .m00_axi_arqos(m00_axi_arqos),
    .m00_axi_arvalid(m00_axi_arvalid), .m00_axi_arready(m00_axi_arready),
    .m00_axi_rid(m00_axi_rid), .m00_axi_rdata(m00_axi_rdata), .m00_axi_rresp(m00_axi_rresp),
    .m00_axi_rlast(m00_axi_rlast), .m00_axi_rvalid(m00_axi_rvalid), .m00_axi_rready(m00_axi_rready)
  );

  typedef struct {
    logic [31:0] addr;
    int          len;
    int          mode;
    int          arp;
    int          rvp;
    int          err_beat;
    bit          early;
    int          exp_nb;
    int          exp_arlen0;
    bit          exp_err;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  // slave configuration and state
  int          ready_mode, arready_pct, rvalid_pct, err_beat;
  bit          early_last;
  logic [31:0] bq_addr[$];
  int          bq_len[$];
  int          beat, gbeat, bidx;
  bit          rv;
  bit          pend_start;

  // observations
  logic [31:0] obs_ar_addr[$];
  int          obs_ar_len[$];
  logic [31:0] obs_data[$];
  int          done_cnt, done_cyc, start_cyc, first_arv_cyc, last_beat_cyc, last_pop_cyc;
  bit          done_err;
  int          proto_bad;
  int          cyc = 0;
  bit          prev_arv;
  logic [31:0] prev_araddr;
  logic [7:0]  prev_arlen;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic step();
    logic [31:0] cur_a;
    logic        exp_rr;
    logic        exp_ov;
    @(negedge clk);
    start_in = pend_start;
    if (pend_start) start_cyc = cyc;
    pend_start = 1'b0;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((cyc % 2) == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    m00_axi_arready = ($urandom_range(0, 99) < arready_pct);
    if (!rv && bq_addr.size() > 0 && $urandom_range(0, 99) < rvalid_pct) rv = 1'b1;
    if (rv) begin
      cur_a         = bq_addr[0] + 32'(beat * 4);
      m00_axi_rdata = mem_word(cur_a);
      m00_axi_rlast = (beat == bq_len[0]) ||
                      (early_last && bidx == 0 && bq_len[0] >= 1 && beat == bq_len[0] - 1);
      m00_axi_rresp = (gbeat == err_beat) ? 2'b10 : 2'b00;
    end else begin
      m00_axi_rdata = $urandom;
      m00_axi_rlast = 1'b0;
      m00_axi_rresp = 2'b00;
    end
    m00_axi_rvalid = rv;
    #1;
    if (rst) begin
      exp_rr = (bq_addr.size() > 0) && out_ready;
      exp_ov = (bq_addr.size() > 0) && rv;
      if (m00_axi_rready !== exp_rr) proto_bad++;
      if (out_valid !== exp_ov) proto_bad++;
      if (out_data !== ((bq_addr.size() > 0) ? m00_axi_rdata : 32'h0)) proto_bad++;
      if (m00_axi_arvalid) begin
        if (!prev_arv) begin
          if (first_arv_cyc < 0) first_arv_cyc = cyc;
          else if (cyc - last_pop_cyc != 1) proto_bad++;
        end else if (m00_axi_araddr !== prev_araddr || m00_axi_arlen !== prev_arlen) proto_bad++;
        if (bq_addr.size() > 0) proto_bad++;
        if (m00_axi_arsize !== 3'd2 || m00_axi_arburst !== 2'b01 || m00_axi_arcache !== 4'b0011) proto_bad++;
      end
      prev_arv    = m00_axi_arvalid && !m00_axi_arready;
      prev_araddr = m00_axi_araddr;
      prev_arlen  = m00_axi_arlen;
      if (m00_axi_arvalid && m00_axi_arready) begin
        obs_ar_addr.push_back(m00_axi_araddr);
        obs_ar_len.push_back(int'(m00_axi_arlen));
        bq_addr.push_back(m00_axi_araddr);
        bq_len.push_back(int'(m00_axi_arlen));
      end else if (rv && m00_axi_rready && bq_addr.size() > 0) begin
        obs_data.push_back(out_data);
        last_beat_cyc = cyc;
        gbeat++;
        rv = 1'b0;
        if (beat == bq_len[0]) begin
          void'(bq_addr.pop_front());
          void'(bq_len.pop_front());
          beat = 0;
          bidx++;
          last_pop_cyc = cyc;
        end else beat++;
      end
    end
    if (done) begin
      done_cnt++;
      done_err = err;
      done_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic begin_xfer(input logic [31:0] a, input int l, input int mode, input int arp,
                            input int rvp, input int eb, input bit early);
    obs_ar_addr.delete(); obs_ar_len.delete(); obs_data.delete();
    bq_addr.delete(); bq_len.delete();
    beat = 0; gbeat = 0; bidx = 0; rv = 1'b0;
    done_cnt = 0; done_err = 1'b0; done_cyc = -1; first_arv_cyc = -1;
    last_beat_cyc = -1; last_pop_cyc = -1; proto_bad = 0; prev_arv = 1'b0;
    ready_mode = mode; arready_pct = arp; rvalid_pct = rvp; err_beat = eb; early_last = early;
    addr_in = a; len_in = 32'(l); pend_start = 1'b1;
  endtask

  task automatic run_xfer(input logic [31:0] a, input int l, input int mode, input int arp,
                          input int rvp, input int eb, input bit early,
                          output int nb, output int arlen0, output bit e);
    logic [31:0] ea[$];
    int          el[$];
    logic [31:0] x, a0;
    int          rem, room, b, n, bad, budget;
    bit          exp_err;
    // reference: walk the block in page- and MAX_BURST-limited chunks
    a0 = a & ~32'h3;
    x = a0;
    rem = l;
    while (rem > 0) begin
      room = (4096 - int'(x[11:0])) / 4;
      b = rem;
      if (b > 16) b = 16;
      if (b > room) b = room;
      ea.push_back(x);
      el.push_back(b - 1);
      x += 32'(b * 4);
      rem -= b;
    end
    exp_err = (eb >= 0 && eb < l) || (early && el.size() > 0 && el[0] >= 1);

    begin_xfer(a, l, mode, arp, rvp, eb, early);
    budget = 3000 + l * 60;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    for (int i = 0; i < 3; i++) step();

    check("done_once", done_cnt, 1);
    check("err", done_err, exp_err);
    check("n_bursts", obs_ar_addr.size(), ea.size());
    bad = 0;
    for (int i = 0; i < obs_ar_addr.size(); i++) begin
      if (i < ea.size() && (obs_ar_addr[i] !== ea[i] || obs_ar_len[i] != el[i])) bad++;
      if (int'(obs_ar_addr[i][11:0]) + (obs_ar_len[i] + 1) * 4 > 4096) bad++;
    end
    check("bursts", bad, 0);
    check("n_beats", obs_data.size(), l);
    bad = 0;
    for (int i = 0; i < obs_data.size(); i++)
      if (obs_data[i] !== mem_word(a0 + 32'(i * 4))) bad++;
    check("beat_data", bad, 0);
    check("protocol", proto_bad, 0);
    if (l == 0) begin
      check("len0_done_lat", done_cyc - start_cyc, 1);
      check("len0_no_ar", first_arv_cyc, -1);
    end else begin
      check("ar_lat", first_arv_cyc - start_cyc, 1);
      check("done_lat", done_cyc - last_beat_cyc, 1);
    end
    nb = obs_ar_addr.size();
    arlen0 = (nb > 0) ? obs_ar_len[0] : -1;
    e = done_err;
  endtask

  vec_t vecs[9];

  initial begin
    int          nb, arlen0, n;
    bit          e;
    logic [31:0] ra;
    int          rl, reb;

    vecs[0] = '{32'h0000_1000, 40, 0, 100, 100, -1, 1'b0, 3, 15, 1'b0};
    vecs[1] = '{32'h0000_0FF8,  8, 0, 100, 100, -1, 1'b0, 2,  1, 1'b0};
    vecs[2] = '{32'h0000_2000,  0, 0, 100, 100, -1, 1'b0, 0,  0, 1'b0};
    vecs[3] = '{32'h0000_2000,  8, 1, 100, 100, -1, 1'b0, 1,  7, 1'b0};
    vecs[4] = '{32'h0000_3000,  8, 0, 100, 100,  3, 1'b0, 1,  7, 1'b1};
    vecs[5] = '{32'h0000_3000, 20, 2,  60,  70, -1, 1'b1, 2, 15, 1'b1};
    vecs[6] = '{32'h0000_1003,  3, 0,  50,  50, -1, 1'b0, 1,  2, 1'b0};
    vecs[7] = '{32'h0000_1FFE,  5, 2,  70,  70, -1, 1'b0, 2,  0, 1'b0};
    vecs[8] = '{32'hFFFF_FFF0,  8, 0, 100, 100, -1, 1'b0, 2,  3, 1'b0};

    rst = 1'b0;
    start_in = 1'b0; addr_in = '0; len_in = '0; out_ready = 1'b1;
    m00_axi_arready = 1'b1; m00_axi_rid = '0; m00_axi_rdata = 32'hFFFF_FFFF;
    m00_axi_rresp = 2'b11; m00_axi_rlast = 1'b1; m00_axi_rvalid = 1'b1;
    pend_start = 1'b0; rv = 1'b0; ready_mode = 0; arready_pct = 100; rvalid_pct = 100;
    err_beat = -1; early_last = 1'b0; done_cnt = 0; proto_bad = 0; prev_arv = 1'b0;
    beat = 0; gbeat = 0; bidx = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_arvalid_rready", {m00_axi_arvalid, m00_axi_rready}, 0);
    check("rst_araddr_arlen", {m00_axi_araddr, m00_axi_arlen}, 0);
    rst = 1'b1;
    m00_axi_rvalid = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_xfer(vecs[i].addr, vecs[i].len, vecs[i].mode, vecs[i].arp, vecs[i].rvp,
               vecs[i].err_beat, vecs[i].early, nb, arlen0, e);
      check("tbl_nbursts", nb, vecs[i].exp_nb);
      if (vecs[i].exp_nb > 0) check("tbl_arlen0", arlen0, vecs[i].exp_arlen0);
      check("tbl_err", e, vecs[i].exp_err);
    end

    // reset in the middle of the data phase of a 16-beat burst
    begin_xfer(32'h0000_4000, 16, 0, 100, 100, -1, 1'b0);
    n = 0;
    while (gbeat < 5 && n < 500) begin
      step();
      n++;
    end
    check("mid_rst_reached_beat5", gbeat, 5);
    check("mid_rst_rready_before", m00_axi_rready, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_arvalid", m00_axi_arvalid, 0);
    check("mid_rst_rready", m00_axi_rready, 0);
    bq_addr.delete(); bq_len.delete(); rv = 1'b0; m00_axi_rvalid = 1'b0;
    done_cnt = 0;
    repeat (3) step();
    check("mid_rst_no_done", done_cnt, 0);
    rst = 1'b1;
    run_xfer(32'h0000_4000, 16, 0, 100, 100, -1, 1'b0, nb, arlen0, e);
    check("post_rst_nbursts", nb, 1);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom & 32'hFFFF_F000;
      if ($urandom_range(0, 1) == 1) ra = ra | 32'(12'hFFF - 12'($urandom_range(0, 160)));
      else ra = ra | ($urandom & 32'hFFF);
      rl = $urandom_range(0, 45);
      reb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 45) : -1;
      run_xfer(ra, rl, $urandom_range(0, 2), $urandom_range(30, 100), $urandom_range(30, 100),
               reb, 1'($urandom_range(0, 4) == 0), nb, arlen0, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_burst_read_master.md
# axi_burst_read_master

Parametrised AXI4 read master that fetches a contiguous block of `len_in` data words starting at `addr_in`. It issues INCR bursts of up to `MAX_BURST` beats, never crossing a 4 KB boundary, and streams the returned beats out through a valid/ready port with backpressure. It sits between a compute or DMA engine and the `m00_axi` read channels. It replaces the single-beat, word-at-a-time reader.

## Interface
- `DATA_W`, 32: AXI data width in bits. Legal values are 32, 64 and 128.
- `ID_W`, 6: AXI ID width in bits.
- `MAX_BURST`, 16: maximum beats per burst, a power of two in the range 1–256.
- `LEN_W`, 32: width of the transfer length in words.
- `clk` in 1: clock.
- `rst` in 1: reset. Asynchronous and active-low: the block resets when `rst == 0`.
- `start_in` in 1: request strobe. Sampled only in `IDLE`.
- `addr_in` in 32: start byte address. The low log2(`DATA_W`/8) bits are forced to zero.
- `len_in` in `LEN_W`: number of `DATA_W` words to read.
- `busy` out 1: high whenever the block is not in `IDLE`.
- `done` out 1: one-cycle pulse when the transfer completes.
- `err` out 1: valid with `done`. Set if any `rresp != 0` or any `rlast` mismatch occurred during the transfer.
- `out_data` out `DATA_W`: read data.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: the consumer accepts the beat.
- `m00_axi_ar*` out: `arid`, `araddr[31:0]`, `arlen[7:0]`, `arsize[2:0]`, `arburst[1:0]`, `arlock`, `arcache[3:0]`, `arprot[2:0]`, `arqos[3:0]`, `arvalid`.
- `m00_axi_arready` in 1.
- `m00_axi_r*` in: `rid[ID_W-1:0]`, `rdata[DATA_W-1:0]`, `rresp[1:0]`, `rlast`, `rvalid`.
- `m00_axi_rready` out 1.

## Operation
- Constant AR fields:
  - `arid` = 0
  - `arburst` = 2'b01 (INCR)
  - `arsize` = log2(`DATA_W`/8)
  - `arlock`, `arprot` and `arqos` = 0
  - `arcache` = 4'b0011
- State `IDLE`: on `start_in`, latch `addr_cur` and `rem` = `len_in`, and clear `err_acc`.
  - If `len_in` = 0, go to `DONE` without any AXI traffic.
  - Otherwise go to `ADDR`.
- State `ADDR`: drive `arvalid` = 1, `araddr` = `addr_cur` and `arlen` = `blen` − 1, where `blen` = min(`rem`, `MAX_BURST`, (4096 − `addr_cur[11:0]`)/(`DATA_W`/8)).
  - `blen` is registered on entry to `ADDR` and held stable until `arready`.
  - On `arvalid && arready`, go to `DATA` and load the beat counter `bcnt` = `blen` − 1.
- State `DATA`:
  - `rready` = `out_ready`.
  - `out_valid` = `rvalid`.
  - `out_data` = `rdata` (combinational pass-through, zero added latency).
- On each handshake (`rvalid && rready`):
  - `err_acc` is ORed with (`rresp != 0`).
  - `err_acc` is ORed with (`rlast != (bcnt == 0)`).
  - `bcnt` decrements.
- When the last beat of a burst (`bcnt == 0`) completes:
  - `rem` −= `blen`.
  - `addr_cur` += `blen`·`DATA_W`/8.
  - If the new `rem` = 0, go to `DONE`; otherwise go to `ADDR`.
- State `DONE`: `done` = 1, `err` = `err_acc`, then go to `IDLE`.
- Only one burst is outstanding at a time. AR for the next burst is issued only after the previous burst's final beat.
- `start_in` outside `IDLE` is ignored.
- Width rules:
  - `rem` is `LEN_W` bits.
  - `blen` is 9 bits.
  - `addr_cur` wraps modulo 2^32. Wrap is not checked.
  - The 4 KB term is evaluated on `addr_cur` after low-bit masking.

## Timing
- Reset values: `busy`, `done`, `err`, `out_valid`, `arvalid` and `rready` are 0; `out_data` is `rdata` gated to 0; `araddr` and `arlen` are 0. All registers are cleared.
- Reset mid-transfer: return to `IDLE` immediately. `arvalid` and `rready` drop asynchronously. No `done` pulse is produced.
- Latency and throughput:
  - `start_in` → `arvalid`: 1 cycle.
  - `len_in` = 0: `done` 1 cycle after `start_in`.
  - Last beat handshake → `done`: 1 cycle.
  - Last beat of a burst → next `arvalid`: 1 cycle.
- `rvalid` while `out_ready` = 0: the beat stalls on the AXI bus. The block buffers nothing.
- `arvalid` with `arready` low: `araddr` and `arlen` are held. `arvalid` does not drop until the handshake.

## Structure
- Package `axi_rd_pkg` holds:
  - `rd_state_t` {`IDLE`, `ADDR`, `DATA`, `DONE`}
  - `AXI_BURST_INCR`
  - `AXI_4K` = 4096
  - function `axi_size(bytes)`
- Sub-module `axi_burst_len_calc` computes `blen` from `rem`, `addr_cur`, `MAX_BURST` and `DATA_W`. It is purely combinational and is reused by the planned write master.

## Test plan
- `DATA_W`=32, `MAX_BURST`=16, `addr_in`=0x1000, `len_in`=40, slave always ready → bursts with `arlen` 15/15/7 at 0x1000/0x1040/0x1080; 40 `out_valid` beats; one `done` with `err`=0.
- `addr_in`=0x0FF8, `len_in`=8 → bursts with `arlen` 1 at 0x0FF8, then `arlen` 5 at 0x1000; no burst crosses 4 KB.
- `len_in`=0 → no `arvalid`; `done` is high exactly 1 cycle after `start_in`.
- `out_ready` toggled 1/0 every cycle, `len_in`=8 → `rready` mirrors `out_ready`; 8 beats delivered in order; no beat lost or duplicated.
- Slave returns `rresp`=2'b10 on beat 3, plus a second run with early `rlast` → `err`=1 at `done`; transfer still completes.
- `rst` pulled low during `DATA` at beat 5 of 16 → `busy`, `arvalid` and `rready` are 0 immediately; next `start_in` performs a clean transfer.
